// File: rtl/data_ram_arbiter.sv
// Two-port (M0 core LSU, M1 DMA/debug) arbiter and access sequencer for the data RAM.
// Grants one requester per cycle, decodes size/alignment into lane selects and returns extended read data a cycle later.
module data_ram_arbiter #(
  parameter int PRIO_MODE  = 0,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [MEM_ADDR_W-1:0] m0_addr_i,
  input  logic [1:0]            m0_size_i,
  input  logic                  m0_unsigned_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m0_err_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [MEM_ADDR_W-1:0] m1_addr_i,
  input  logic [1:0]            m1_size_i,
  input  logic                  m1_unsigned_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic                  m1_err_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [MEM_ADDR_W-1:0] ram_addr_o,
  output logic [3:0]            ram_sel_o,
  output logic [31:0]           ram_data_o,
  input  logic [31:0]           ram_data_i
);

  typedef enum logic {GNT_M0 = 1'b0, GNT_M1 = 1'b1} port_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: access_legal = 1'b1;
      SZ_HALF: access_legal = ~a[0];
      SZ_WORD: access_legal = (a == 2'b00);
      default: access_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_sel = 4'b0001 << a;
      SZ_HALF: lane_sel = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: replicate_lanes = {4{wdata[7:0]}};
      SZ_HALF: replicate_lanes = {2{wdata[15:0]}};
      default: replicate_lanes = wdata;
    endcase
  endfunction

  // Shift the addressed lane(s) down to bit 0, then zero- or sign-extend.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] a,
                                              input logic uns, input logic [31:0] word);
    logic signed [31:0] shifted;
    shifted = word >> {a, 3'b000};
    case (size)
      SZ_BYTE: load_extend = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_extend = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  port_e                 last_grant;
  logic                  gnt0, gnt1, any_gnt, acc_ok;
  logic                  sel_we, sel_uns;
  logic [MEM_ADDR_W-1:0] sel_addr;
  logic [1:0]            sel_size;
  logic [31:0]           sel_wdata;

  logic                  vld0_p1, vld1_p1, err_p1;
  logic [31:0]           rdata_p1;

  // Stage p0: arbitration, decode and RAM drive (combinational, gated by reset)
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (m0_req_i && (!m1_req_i || PRIO_MODE == 1 || last_grant == GNT_M1)) gnt0 = 1'b1;
      else if (m1_req_i)                                                      gnt1 = 1'b1;
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? m1_we_i       : m0_we_i;
    sel_uns   = gnt1 ? m1_unsigned_i : m0_unsigned_i;
    sel_addr  = gnt1 ? m1_addr_i     : m0_addr_i;
    sel_size  = gnt1 ? m1_size_i     : m0_size_i;
    sel_wdata = gnt1 ? m1_wdata_i    : m0_wdata_i;
    acc_ok    = any_gnt & access_legal(sel_size, sel_addr[1:0]);
  end

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = 4'b0000;
    ram_data_o = 32'h0;
    if (acc_ok) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = sel_we;
      ram_addr_o = sel_addr;
      ram_sel_o  = lane_sel(sel_size, sel_addr[1:0]);
      ram_data_o = replicate_lanes(sel_size, sel_wdata);
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Stage p1: registered response; rdata is cleared on reset so no stale data leaks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_M1;
      vld0_p1    <= 1'b0;
      vld1_p1    <= 1'b0;
      err_p1     <= 1'b0;
      rdata_p1   <= 32'h0;
    end else begin
      if (gnt0)      last_grant <= GNT_M0;
      else if (gnt1) last_grant <= GNT_M1;
      vld0_p1  <= gnt0;
      vld1_p1  <= gnt1;
      err_p1   <= any_gnt & ~acc_ok;
      rdata_p1 <= (acc_ok && !sel_we) ? load_extend(sel_size, sel_addr[1:0], sel_uns, ram_data_i)
                                      : 32'h0;
    end
  end

  assign m0_rvalid_o = vld0_p1;
  assign m0_err_o    = vld0_p1 & err_p1;
  assign m0_rdata_o  = vld0_p1 ? rdata_p1 : 32'h0;
  assign m1_rvalid_o = vld1_p1;
  assign m1_err_o    = vld1_p1 & err_p1;
  assign m1_rdata_o  = vld1_p1 ? rdata_p1 : 32'h0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: vector table plus scoreboard of responses, with a
// round-robin instance (u_rr, backed by a RAM model) and a fixed-priority instance (u_fp).
module tb_data_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_uns, m1_req, m1_we, m1_uns;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]  m0_size, m1_size;

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_data, ram_rdata;
  logic [3:0]  ram_sel;

  logic        m0_gnt_b, m0_rvalid_b, m0_err_b, m1_gnt_b, m1_rvalid_b, m1_err_b;
  logic [31:0] m0_rdata_b, m1_rdata_b;
  logic        ram_ce_b, ram_we_b;
  logic [31:0] ram_addr_b, ram_data_b;
  logic [3:0]  ram_sel_b;

  logic [31:0] mem [0:63] = '{default: 32'h0};

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        exp_ce;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[14];

  data_ram_arbiter #(.PRIO_MODE(0), .MEM_ADDR_W(32)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_size_i(m0_size),
    .m0_unsigned_i(m0_uns), .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt),
    .m0_rvalid_o(m0_rvalid), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_size_i(m1_size),
    .m1_unsigned_i(m1_uns), .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
    .ram_data_o(ram_data), .ram_data_i(ram_rdata)
  );

  data_ram_arbiter #(.PRIO_MODE(1), .MEM_ADDR_W(32)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_size_i(m0_size),
    .m0_unsigned_i(m0_uns), .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt_b),
    .m0_rvalid_o(m0_rvalid_b), .m0_err_o(m0_err_b), .m0_rdata_o(m0_rdata_b),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_size_i(m1_size),
    .m1_unsigned_i(m1_uns), .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt_b),
    .m1_rvalid_o(m1_rvalid_b), .m1_err_o(m1_err_b), .m1_rdata_o(m1_rdata_b),
    .ram_ce_o(ram_ce_b), .ram_we_o(ram_we_b), .ram_addr_o(ram_addr_b), .ram_sel_o(ram_sel_b),
    .ram_data_o(ram_data_b), .ram_data_i(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, byte-lane write at the rising edge
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_data[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response monitor: one cycle after each push, the expected port must answer
  always @(posedge clk) begin
    resp_t r;
    #1;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("rvalid", {30'h0, m1_rvalid, m0_rvalid}, r.port ? 32'd2 : 32'd1);
      chk("resp_err", 32'(r.port ? m1_err : m0_err), 32'(r.err));
      chk("resp_rdata", r.port ? m1_rdata : m0_rdata, r.rdata);
    end else begin
      chk("idle_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'd0);
    end
  end

  task automatic drive(input vec_t v);
    m0_req = ~v.port; m1_req = v.port;
    if (v.port) begin
      m1_we = v.we; m1_addr = v.addr; m1_size = v.size; m1_uns = v.uns; m1_wdata = v.wdata;
    end else begin
      m0_we = v.we; m0_addr = v.addr; m0_size = v.size; m0_uns = v.uns; m0_wdata = v.wdata;
    end
  endtask

  initial begin
    //          port  we    addr       size   uns   wdata          ce    sel    ram_data       err   rdata
    vecs[0]  = '{1'b0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h13, 2'b00, 1'b0, 32'h000000A5, 1'b1, 4'h8, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0,        1'b1, 4'h8, 32'h0,        1'b0, 32'hFFFFFFA5};
    vecs[4]  = '{1'b1, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0,        1'b1, 4'h8, 32'h0,        1'b0, 32'h000000A5};
    vecs[5]  = '{1'b0, 1'b1, 32'h22, 2'b01, 1'b0, 32'h00008001, 1'b1, 4'hC, 32'h80018001, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h22, 2'b01, 1'b0, 32'h0,        1'b1, 4'hC, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[7]  = '{1'b1, 1'b0, 32'h12, 2'b00, 1'b0, 32'h0,        1'b1, 4'h4, 32'h0,        1'b0, 32'hFFFFFFAD};
    vecs[8]  = '{1'b0, 1'b0, 32'h10, 2'b01, 1'b1, 32'h0,        1'b1, 4'h3, 32'h0,        1'b0, 32'h0000BEEF};
    vecs[9]  = '{1'b0, 1'b0, 32'h11, 2'b10, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'h23, 2'b01, 1'b0, 32'h00001234, 1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h10, 2'b11, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h11, 2'b00, 1'b1, 32'h0,        1'b1, 4'h2, 32'h0,        1'b0, 32'h000000BE};
    vecs[13] = '{1'b0, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0,        1'b0, 32'h80010000};

    // Reset with both ports requesting: nothing may be granted or enabled
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_size = 2'b10; m0_uns = 1'b0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4; m1_size = 2'b10; m1_uns = 1'b0; m1_wdata = 32'h0;
    #12;
    chk("rst_gnt", {30'h0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_ce", 32'(ram_ce), 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_err", {30'h0, m1_err, m0_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back
    for (int i = 0; i < 14; i++) begin
      resp_t r;
      drive(vecs[i]);
      #1;
      chk($sformatf("gnt[%0d]", i), {30'h0, m1_gnt, m0_gnt}, vecs[i].port ? 32'd2 : 32'd1);
      chk($sformatf("ce[%0d]", i), 32'(ram_ce), 32'(vecs[i].exp_ce));
      chk($sformatf("we[%0d]", i), 32'(ram_we), 32'(vecs[i].exp_ce & vecs[i].we));
      chk($sformatf("sel[%0d]", i), 32'(ram_sel), 32'(vecs[i].exp_sel));
      if (vecs[i].exp_ce && vecs[i].we)
        chk($sformatf("wdata[%0d]", i), ram_data, vecs[i].exp_data);
      r.port = vecs[i].port; r.err = vecs[i].exp_err; r.rdata = vecs[i].exp_rdata;
      sb.push_back(r);
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("mem_0x10", mem[4], 32'hA5ADBEEF);
    chk("mem_0x20", mem[8], 32'h80010000);

    // Reset pulsed during a granted store
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_size = 2'b10; m0_wdata = 32'h11223344;
    #1;
    chk("pre_rst_gnt", 32'(m0_gnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ce", 32'(ram_ce), 32'd0);
    chk("mid_rst_gnt", 32'(m0_gnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; m0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mem_0x30_unwritten", mem[12], 32'h0);

    // Continuous contention for 6 cycles: word loads from 0x10 on both ports
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_size = 2'b10; m0_uns = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_size = 2'b10; m1_uns = 1'b0;
    for (int i = 0; i < 6; i++) begin
      resp_t r;
      #1;
      chk($sformatf("rr_gnt[%0d]", i), {30'h0, m1_gnt, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("fp_gnt[%0d]", i), {30'h0, m1_gnt_b, m0_gnt_b}, 32'd1);
      r.port = (i % 2 != 0); r.err = 1'b0; r.rdata = 32'hA5ADBEEF;
      sb.push_back(r);
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
